// File: rtl/cdb_arbiter_if.sv
// Signal bundle between the execution-unit result ports, the CDB arbiter and the CDB consumers.
interface cdb_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int PEND_W = $clog2(NUM_CH * FIFO_DEPTH + 1);

    logic                     flush;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*TAG_W-1:0]  ch_tag;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [PEND_W-1:0]        pending;

    modport master (
        output flush, ch_valid, ch_tag, ch_data,
        input  ch_ready, cdb_valid, cdb_tag, cdb_data, pending
    );

    modport slave (
        input  flush, ch_valid, ch_tag, ch_data,
        output ch_ready, cdb_valid, cdb_tag, cdb_data, pending
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-channel result FIFOs feeding a round-robin, one-per-cycle common data bus broadcast.
// Define CDB_ARB_BYPASS_EN to let an input arriving at an empty FIFO reach the CDB in one edge.
module cdb_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PEND_W = $clog2(NUM_CH * FIFO_DEPTH + 1);
    localparam int ENT_W  = TAG_W + DATA_W;

    logic [ENT_W-1:0]  mem    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;

    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] cand;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt;
    logic [CH_W-1:0]   scan;
    logic [ENT_W-1:0]  gnt_ent;
    logic [PEND_W-1:0] n_wr;

    // Ready looks only at the stored count, so a full FIFO refuses even while it pops.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.ch_ready = ready;

    always_comb begin
        push    = bus.ch_valid & ready;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt     = '0;
        scan    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = (count[i] != '0);
`ifdef CDB_ARB_BYPASS_EN
            cand[i] = cand[i] | push[i];
`endif
        end
        for (int k = 0; k < NUM_CH; k++) begin
            scan = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!gnt_vld && cand[scan]) begin
                gnt_vld = 1'b1;
                gnt     = scan;
            end
        end
        gnt_ent = mem[gnt][rd_ptr[gnt]];
`ifdef CDB_ARB_BYPASS_EN
        if (count[gnt] == '0) begin
            gnt_ent = {bus.ch_tag[int'(gnt)*TAG_W +: TAG_W], bus.ch_data[int'(gnt)*DATA_W +: DATA_W]};
        end
`endif
        n_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]   = gnt_vld && (gnt == CH_W'(i)) && (count[i] != '0);
            wr_en[i] = push[i];
`ifdef CDB_ARB_BYPASS_EN
            if (gnt_vld && (gnt == CH_W'(i)) && (count[i] == '0)) begin
                wr_en[i] = 1'b0;
            end
`endif
            n_wr = n_wr + PEND_W'(wr_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i] && !bus.flush) begin
                mem[i][wr_ptr[i]] <= {bus.ch_tag[i*TAG_W +: TAG_W], bus.ch_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr        <= '0;
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.pending   <= '0;
        end else if (bus.flush) begin
            // rr_ptr survives a flush so fairness continues across it.
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            bus.cdb_valid <= 1'b0;
            bus.pending   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
            end
            bus.cdb_valid <= gnt_vld;
            if (gnt_vld) begin
                bus.cdb_tag  <= gnt_ent[ENT_W-1 -: TAG_W];
                bus.cdb_data <= gnt_ent[DATA_W-1:0];
                rr_ptr       <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
            end
            bus.pending <= bus.pending + n_wr - PEND_W'(|pop);
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter with a queue-based reference model and scoreboard.
module tb_cdb_arbiter;
    localparam int NUM_CH     = 4;
    localparam int TAG_W      = 6;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int ENT_W      = TAG_W + DATA_W;
`ifdef CDB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    cdb_arbiter_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();
    cdb_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one queue per channel, a round-robin start index, one pop per edge.
    logic [ENT_W-1:0]  mq  [NUM_CH][$];
    logic [ENT_W-1:0]  src [NUM_CH][$];
    logic [ENT_W-1:0]  exp_q [$];
    logic [TAG_W-1:0]  bc_log [$];
    int                m_rr = 0;
    bit                m_valid = 1'b0;
    logic [TAG_W-1:0]  m_tag = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit [NUM_CH-1:0]   m_acc = '0;

    function automatic logic [ENT_W-1:0] in_ent(input int i);
        return {bus.ch_tag[i*TAG_W +: TAG_W], bus.ch_data[i*DATA_W +: DATA_W]};
    endfunction

    function automatic int m_pend();
        int s = 0;
        for (int i = 0; i < NUM_CH; i++) s += mq[i].size();
        return s;
    endfunction

    function automatic logic [NUM_CH-1:0] m_ready();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = (mq[i].size() != FIFO_DEPTH);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int g;
        int c;
        bit [NUM_CH-1:0] take;
        logic [ENT_W-1:0] e;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            exp_q.delete();
            m_rr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_acc = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) take[i] = bus.ch_valid[i] && (mq[i].size() < FIFO_DEPTH);
            if (bus.flush) begin
                for (int i = 0; i < NUM_CH; i++) mq[i].delete();
                m_valid = 1'b0;
                m_acc = '0;
            end else begin
                m_acc = take;
                g = -1;
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_rr + k) % NUM_CH;
                    if (g < 0 && (mq[c].size() > 0 || (BYP && take[c]))) g = c;
                end
                m_valid = (g >= 0);
                if (g >= 0) begin
                    if (mq[g].size() > 0) e = mq[g].pop_front();
                    else begin
                        e = in_ent(g);
                        take[g] = 1'b0;
                    end
                    {m_tag, m_data} = e;
                    exp_q.push_back(e);
                    m_rr = (g + 1) % NUM_CH;
                end
                for (int i = 0; i < NUM_CH; i++) if (take[i]) mq[i].push_back(in_ent(i));
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic [ENT_W-1:0] e;
        forever begin
            @(negedge clk);
            check("cdb_valid", bus.cdb_valid, m_valid);
            if (bus.cdb_valid) begin
                bc_log.push_back(bus.cdb_tag);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bcast_unexpected at %0t: got tag 0x%0h, expected no broadcast", $time, bus.cdb_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("cdb_tag", bus.cdb_tag, e[ENT_W-1 -: TAG_W]);
                    check("cdb_data", bus.cdb_data, e[DATA_W-1:0]);
                end
            end else begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                check("cdb_tag_hold", bus.cdb_tag, m_tag);
            end
            check("pending", bus.pending, m_pend());
            check("ch_ready", bus.ch_ready, m_ready());
        end
    end

    // Producer driver: presents the head of each source queue until the model reports it taken.
    initial begin : driver
        bus.ch_valid = '0;
        bus.ch_tag   = '0;
        bus.ch_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_acc[i] && src[i].size() > 0) void'(src[i].pop_front());
                bus.ch_valid[i] = (src[i].size() > 0);
                if (src[i].size() > 0) {bus.ch_tag[i*TAG_W +: TAG_W], bus.ch_data[i*DATA_W +: DATA_W]} = src[i][0];
            end
        end
    end

    function automatic bit src_empty();
        for (int i = 0; i < NUM_CH; i++) if (src[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(src_empty() && m_pend() == 0 && !bus.cdb_valid) && n < 300) begin
            @(negedge clk); #2;
            n++;
        end
        check({name, "_drain"}, n < 300, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int lat, nv, idx, n3;
        int pend_exp [5];
        bit saw_low;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Reset then idle
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("idle_valid", bus.cdb_valid, 0);
            check("idle_pending", bus.pending, 0);
            check("idle_ready", bus.ch_ready, 4'hF);
        end
        #1;

        // Single push on channel 2: latency in edges
        bc_log.delete();
        src[2].push_back({6'd5, 32'd126});
        lat = -1; nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (bus.cdb_valid) begin
                nv++;
                if (lat < 0) lat = k;
            end
        end
        #1;
        check("single_latency", lat, BYP ? 1 : 2);
        check("single_count", nv, 1);
        check("single_tag", bc_log.size() > 0 ? bc_log[0] : 6'h3F, 5);

        // All channels at once from rr_ptr = 0
        pulse_reset();
        bc_log.delete();
        for (int i = 0; i < NUM_CH; i++) src[i].push_back({TAG_W'(i + 1), DATA_W'($urandom)});
        pend_exp = BYP ? '{3, 2, 1, 0, 0} : '{4, 3, 2, 1, 0};
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("all4_pending_seq", bus.pending, pend_exp[k]);
        end
        #1;
        wait_idle("all4");
        check("all4_count", bc_log.size(), 4);
        for (int i = 0; i < NUM_CH && i < bc_log.size(); i++) check("all4_order", bc_log[i], i + 1);

        // Channel 0 streaming, channel 1 once
        bc_log.delete();
        for (int s = 0; s < 10; s++) src[0].push_back({2'd0, 4'(s), DATA_W'($urandom)});
        src[1].push_back({2'd1, 4'd0, DATA_W'($urandom)});
        wait_idle("fair");
        idx = -1;
        for (int k = 0; k < bc_log.size(); k++) if (idx < 0 && bc_log[k] == 6'd16) idx = k;
        check("fair_ch1_within2", (idx >= 0) && (idx < 2), 1);
        check("fair_count", bc_log.size(), 11);

        // Channel 3 overfills while channels 0-2 are saturated
        bc_log.delete();
        for (int i = 0; i < 3; i++)
            for (int s = 0; s < 12; s++) src[i].push_back({2'(i), 4'(s), DATA_W'($urandom)});
        repeat (6) @(negedge clk);
        #2;
        nv = 0;
        while (m_rr != 1 && nv < 20) begin
            @(negedge clk); #2;
            nv++;
        end
        check("sat_rr_align", nv < 20, 1);
        for (int s = 0; s < 5; s++) src[3].push_back({2'd3, 4'(s), DATA_W'($urandom)});
        saw_low = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (!bus.ch_ready[3]) saw_low = 1'b1;
        end
        #1;
`ifndef CDB_ARB_BYPASS_EN
        check("sat_ready3_drop", saw_low, 1);
`endif
        wait_idle("sat");
        n3 = 0;
        for (int k = 0; k < bc_log.size(); k++) begin
            if (bc_log[k][5:4] == 2'd3) begin
                check("sat_ch3_order", bc_log[k][3:0], n3);
                n3++;
            end
        end
        check("sat_ch3_count", n3, 5);
        check("sat_total", bc_log.size(), 41);

        // Flush with entries pending
        for (int i = 0; i < NUM_CH; i++) src[i].push_back({TAG_W'(40 + i), DATA_W'($urandom)});
        repeat (3) @(negedge clk);
        #2 bus.flush = 1'b1;
        @(negedge clk); #1;
        check("flush_valid", bus.cdb_valid, 0);
        check("flush_pending", bus.pending, 0);
        #1 bus.flush = 1'b0;
        bc_log.delete();
        src[1].push_back({6'd9, DATA_W'($urandom)});
        wait_idle("post_flush");
        check("post_flush_count", bc_log.size(), 1);
        check("post_flush_tag", bc_log.size() > 0 ? bc_log[0] : 6'h3F, 9);

        // Asynchronous reset mid-burst
        for (int i = 0; i < NUM_CH; i++)
            for (int s = 0; s < 3; s++) src[i].push_back({2'(i), 4'(s), DATA_W'($urandom)});
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", bus.cdb_valid, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_ready", bus.ch_ready, 4'hF);
        check("rst_tag", bus.cdb_tag, 0);
        @(negedge clk); #2 rst = 1'b0;
        wait_idle("post_rst");

        // Random traffic with occasional flush
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #2;
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(2) == 0 && src[i].size() < 3)
                    src[i].push_back({2'(i), 4'($urandom), DATA_W'($urandom)});
            bus.flush = ($urandom_range(63) == 0);
        end
        @(negedge clk); #2 bus.flush = 1'b0;
        wait_idle("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects completed results from NUM_CH execution queues (int, mult, div, mem) into per-channel FIFOs.
- Broadcasts at most one result per cycle on the common data bus (tag/valid/data).
- Arbitrates between channels round-robin.
- Replaces the fixed-sequence CDB driver with a parametrised, back-pressured broadcast stage between the execution units and the reservation stations / register file.

Parameters:
- NUM_CH, 4, number of producing channels (index 0 = int, 1 = mult, 2 = div, 3 = mem).
- TAG_W, 6, width of a result tag.
- DATA_W, 32, width of result data.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all pending results.
- ch_valid  in  NUM_CH  per-channel result valid.
- ch_tag  in  NUM_CH*TAG_W  per-channel tag; channel i occupies bits [i*TAG_W +: TAG_W].
- ch_data  in  NUM_CH*DATA_W  per-channel data, packed the same way.
- ch_ready  out  NUM_CH  per-channel FIFO not full.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast data.
- pending  out  $clog2(NUM_CH*FIFO_DEPTH+1)  total queued entries, excluding the broadcast currently on the CDB.

Behaviour:

Reset:
- On rst, asynchronously:
  - all FIFO pointers and counts = 0;
  - rr_ptr = 0;
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0;
  - pending = 0;
  - ch_ready = all ones.
- Reset mid-operation discards all queued entries with no broadcast.

Push:
- Channel i accepts at a rising edge when ch_valid[i] & ch_ready[i].
- ch_ready[i] = (count[i] != FIFO_DEPTH); it depends only on the FIFO count, never on the same-cycle pop.
- A full FIFO therefore refuses a push even in a cycle where it pops.
- Valid without ready: the producer holds tag/data stable; nothing is dropped silently.

Arbitration and broadcast:
- Candidates each cycle are channels with a non-empty FIFO.
- Grant goes to the first candidate scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH.
- The granted head is popped, and cdb_valid/tag/data are registered at the same edge.
- After a grant to channel g: rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- With no candidate: cdb_valid <= 0; cdb_tag and cdb_data hold their last value.
- cdb_valid is high for exactly one cycle per broadcast entry; back-to-back broadcasts are allowed every cycle.

Latency:
- Input sampled at edge 0 into an empty FIFO.
- That entry is eligible in the cycle after edge 0.
- If granted, it is on the CDB after edge 1: two-edge latency.

FIFO:
- Circular buffer; read/write pointers wrap at FIFO_DEPTH.
- Simultaneous push and pop on the same channel is legal; count is unchanged.

pending:
- Registered sum of all counts.
- Updated each edge by +pushes − (1 if a grant occurred).

flush:
- Sampled at an edge; takes priority over push and pop.
- At that edge: all counts/pointers = 0, cdb_valid <= 0, pending <= 0.
- rr_ptr is retained.
- Inputs in the flush cycle are not accepted; ch_ready still reflects pre-flush counts that cycle.

Simultaneous events:
- All NUM_CH channels may push in the same cycle; each lands in its own FIFO.
- Only one entry is popped per cycle.
- Starvation bound: a non-empty channel is granted within NUM_CH cycles.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined: a channel whose FIFO is empty and whose ch_valid & ch_ready is high joins arbitration in the same cycle.
  - If granted, its input goes directly to the CDB at edge 0: one-edge latency, and it is not written into the FIFO.
  - If not granted, it is written to the FIFO as normal.
  - pending does not count a bypassed entry.
- Undefined: behaviour is exactly as in Behaviour (two-edge minimum latency); no bypass path is generated.

Test Plan:
1. Reset then idle, 5 cycles:
   - cdb_valid = 0, pending = 0, ch_ready = 4'b1111 throughout.
2. Single push on channel 2 (tag 6'd5, data 32'd126) for one cycle:
   - Without bypass: cdb_valid high for exactly one cycle, two edges later, with tag 5 / data 126.
   - With CDB_ARB_BYPASS_EN: one edge later.
3. All 4 channels push once in the same cycle (tags 1, 2, 3, 4), rr_ptr = 0:
   - CDB broadcasts tags 1, 2, 3, 4 on 4 consecutive cycles.
   - pending goes 4 → 3 → 2 → 1 → 0.
4. Channel 0 pushes every cycle while channel 1 pushes once:
   - Channel 1's tag appears on the CDB within 2 broadcasts.
   - Grants alternate 0, 1, 0 …
5. Channel 3 pushes 5 entries back-to-back with FIFO_DEPTH = 4 while channels 0–2 are saturated:
   - ch_ready[3] drops after 4 accepted entries.
   - The 5th is held and accepted only after a pop.
   - All 5 tags are broadcast in order, none lost or duplicated.
6. Flush with 3 entries pending:
   - Next cycle cdb_valid = 0 and pending = 0.
   - A subsequent push with tag 9 broadcasts tag 9 only.
   - Separately, asserting rst mid-burst clears the outputs immediately.
